// File: rtl/unidade_controle_drone.sv
// Moore sequencer for the drone-game datapath: strobes, win/loss flags, debug state code.
// Outputs follow the state register (desloca also gates on timeout); no backpressure, buttons are edge-detected.
module unidade_controle_drone #(
    parameter int CHECA_CICLOS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       confirma,
    input  logic       colisao,
    input  logic       timeout,
    input  logic       fim_mapa,
    input  logic       borda_movimento,
    output logic       zeraPosicoes,
    output logic       resetaVidas,
    output logic       contaT,
    output logic       zeraT,
    output logic       desloca,
    output logic       escolhe_modo,
    output logic       escolhe_vida,
    output logic       checa_colisao,
    output logic       ganhou,
    output logic       perdeu,
    output logic       perdeu_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        ESCOLHE_MODO  = 4'h2,
        ESCOLHE_VIDA  = 4'h3,
        INICIA_JOGO   = 4'h4,
        ESPERA_JOGADA = 4'h5,
        CHECA         = 4'h6,
        PROXIMA       = 4'h7,
        GANHOU        = 4'hA,
        PERDEU        = 4'hE
    } estado_t;

    localparam logic [2:0] CNT_FIM = 3'(CHECA_CICLOS - 1);

    estado_t    estado;
    estado_t    prox_estado;
    logic [2:0] cnt;
    logic       causa_timeout;
    logic       ini_ant;
    logic       conf_ant;
    logic       ini_ed;
    logic       conf_ed;

    assign ini_ed  = iniciar & ~ini_ant;
    assign conf_ed = confirma & ~conf_ant;

    // Previous-button registers reset high so a button held through reset is not an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= INICIAL;
            cnt           <= 3'd0;
            causa_timeout <= 1'b0;
            ini_ant       <= 1'b1;
            conf_ant      <= 1'b1;
        end else begin
            estado   <= prox_estado;
            ini_ant  <= iniciar;
            conf_ant <= confirma;
            if (estado == CHECA)
                cnt <= cnt + 3'd1;
            else
                cnt <= 3'd0;
            if (estado == ESPERA_JOGADA && timeout)
                causa_timeout <= 1'b1;
            else if (estado == CHECA && colisao)
                causa_timeout <= 1'b0;
        end
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            INICIAL:       if (ini_ed) prox_estado = PREPARA;
            PREPARA:       prox_estado = ESCOLHE_MODO;
            ESCOLHE_MODO:  if (conf_ed) prox_estado = ESCOLHE_VIDA;
            ESCOLHE_VIDA:  if (conf_ed) prox_estado = INICIA_JOGO;
            INICIA_JOGO:   prox_estado = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (timeout)
                    prox_estado = PERDEU;
                else if (borda_movimento)
                    prox_estado = CHECA;
            end
            CHECA: begin
                if (colisao)
                    prox_estado = PERDEU;
                else if (cnt == CNT_FIM)
                    prox_estado = fim_mapa ? GANHOU : PROXIMA;
            end
            PROXIMA:       prox_estado = ESPERA_JOGADA;
            GANHOU:        if (ini_ed) prox_estado = PREPARA;
            PERDEU:        if (ini_ed) prox_estado = PREPARA;
            default:       prox_estado = INICIAL;
        endcase
    end

    always_comb begin
        zeraPosicoes   = 1'b0;
        resetaVidas    = 1'b0;
        contaT         = 1'b0;
        zeraT          = 1'b0;
        desloca        = 1'b0;
        escolhe_modo   = 1'b0;
        escolhe_vida   = 1'b0;
        checa_colisao  = 1'b0;
        ganhou         = 1'b0;
        perdeu         = 1'b0;
        perdeu_timeout = 1'b0;
        db_estado      = estado;
        case (estado)
            PREPARA: begin
                zeraPosicoes = 1'b1;
                resetaVidas  = 1'b1;
                zeraT        = 1'b1;
            end
            ESCOLHE_MODO:  escolhe_modo = 1'b1;
            ESCOLHE_VIDA:  escolhe_vida = 1'b1;
            INICIA_JOGO: begin
                zeraPosicoes = 1'b1;
                zeraT        = 1'b1;
            end
            ESPERA_JOGADA: begin
                contaT  = 1'b1;
                // An expiring timer wins over a simultaneous move.
                desloca = ~timeout;
            end
            CHECA:         checa_colisao = 1'b1;
            PROXIMA:       zeraT = 1'b1;
            GANHOU:        ganhou = 1'b1;
            PERDEU: begin
                perdeu         = 1'b1;
                perdeu_timeout = causa_timeout;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_drone.sv
// Bench for unidade_controle_drone: directed game walk-through plus random play against a game-rule model.
module tb_unidade_controle_drone;

    localparam int C = 2;

    logic       clock = 1'b0;
    logic       reset, iniciar, confirma, colisao, timeout, fim_mapa, borda_movimento;
    logic       zeraPosicoes, resetaVidas, contaT, zeraT, desloca, escolhe_modo, escolhe_vida;
    logic       checa_colisao, ganhou, perdeu, perdeu_timeout;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: game phase code, remaining check cycles, loss cause, last button levels.
    int m_fase;
    int m_janela;
    bit m_causa;
    bit m_ini_ant;
    bit m_conf_ant;

    unidade_controle_drone #(.CHECA_CICLOS(C)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .confirma(confirma),
        .colisao(colisao), .timeout(timeout), .fim_mapa(fim_mapa),
        .borda_movimento(borda_movimento), .zeraPosicoes(zeraPosicoes),
        .resetaVidas(resetaVidas), .contaT(contaT), .zeraT(zeraT), .desloca(desloca),
        .escolhe_modo(escolhe_modo), .escolhe_vida(escolhe_vida),
        .checa_colisao(checa_colisao), .ganhou(ganhou), .perdeu(perdeu),
        .perdeu_timeout(perdeu_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [15:0] got, input logic [15:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nome, got, req, $time);
        end
    endtask

    function automatic logic [10:0] dut_outs();
        return {zeraPosicoes, resetaVidas, contaT, zeraT, desloca, escolhe_modo,
                escolhe_vida, checa_colisao, ganhou, perdeu, perdeu_timeout};
    endfunction

    // Expected strobes per phase, same bit order as dut_outs().
    function automatic logic [10:0] exp_outs(input int fase, input bit cause, input logic tmo);
        case (fase)
            1:  return 11'b11010000000;
            2:  return 11'b00000100000;
            3:  return 11'b00000010000;
            4:  return 11'b10010000000;
            5:  return {4'b0010, ~tmo, 6'b000000};
            6:  return 11'b00000001000;
            7:  return 11'b00010000000;
            10: return 11'b00000000100;
            14: return {10'b0000000001, cause};
            default: return 11'b0;
        endcase
    endfunction

    task automatic model_step();
        bit ie, ce;
        ie = iniciar && !m_ini_ant;
        ce = confirma && !m_conf_ant;
        if (reset) begin
            m_fase = 0; m_causa = 0; m_janela = 0;
            m_ini_ant = 1; m_conf_ant = 1;
            return;
        end
        case (m_fase)
            0:  if (ie) m_fase = 1;
            1:  m_fase = 2;
            2:  if (ce) m_fase = 3;
            3:  if (ce) m_fase = 4;
            4:  m_fase = 5;
            5: begin
                if (timeout) begin m_fase = 14; m_causa = 1; end
                else if (borda_movimento) begin m_fase = 6; m_janela = C; end
            end
            6: begin
                m_janela--;
                if (colisao) begin m_fase = 14; m_causa = 0; end
                else if (m_janela == 0) m_fase = fim_mapa ? 10 : 7;
            end
            7:  m_fase = 5;
            10, 14: if (ie) m_fase = 1;
            default: m_fase = 0;
        endcase
        m_ini_ant = iniciar;
        m_conf_ant = confirma;
    endtask

    task automatic compare();
        chk("db_estado", 16'(db_estado), 16'(m_fase));
        chk("outputs", 16'(dut_outs()), 16'(exp_outs(m_fase, m_causa, timeout)));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare();
    endtask

    initial begin
        m_fase = 0; m_causa = 0; m_janela = 0; m_ini_ant = 1; m_conf_ant = 1;
        reset = 1; iniciar = 1; confirma = 0; colisao = 0; timeout = 0;
        fim_mapa = 0; borda_movimento = 0;

        // 1: iniciar held through reset is not a start.
        tick();
        chk("reset_db", 16'(db_estado), 16'h0);
        chk("reset_outs", 16'(dut_outs()), 16'h0);
        reset = 0;
        tick(); tick();
        chk("held_iniciar", 16'(db_estado), 16'h0);
        iniciar = 0; tick();
        iniciar = 1; tick();
        chk("prepara_db", 16'(db_estado), 16'h1);
        chk("prepara_outs", 16'({zeraPosicoes, resetaVidas, zeraT}), 16'b111);
        tick();
        chk("modo_db", 16'(db_estado), 16'h2);

        // 2: confirma held does not skip ESCOLHE_VIDA.
        confirma = 1; tick();
        tick();
        chk("vida_held", 16'(db_estado), 16'h3);
        confirma = 0; tick();
        confirma = 1; tick();
        chk("inicia_db", 16'(db_estado), 16'h4);
        chk("inicia_zera", 16'(zeraPosicoes), 16'h1);
        confirma = 0; tick();
        chk("espera_db", 16'(db_estado), 16'h5);
        chk("espera_outs", 16'({contaT, desloca}), 16'b11);

        // 3: check window lasts exactly C cycles, then PROXIMA, then back.
        borda_movimento = 1; tick();
        borda_movimento = 0;
        chk("checa1", 16'({db_estado, checa_colisao}), 16'({4'h6, 1'b1}));
        tick();
        chk("checa2", 16'({db_estado, checa_colisao}), 16'({4'h6, 1'b1}));
        tick();
        chk("proxima", 16'({db_estado, zeraT}), 16'({4'h7, 1'b1}));
        tick();
        chk("volta_espera", 16'(db_estado), 16'h5);

        // 4: collision on the last check cycle beats fim_mapa.
        borda_movimento = 1; tick();
        borda_movimento = 0; tick();
        colisao = 1; fim_mapa = 1; tick();
        colisao = 0; fim_mapa = 0;
        chk("perdeu_col", 16'({db_estado, perdeu, perdeu_timeout}), 16'({4'hE, 2'b10}));
        iniciar = 0; tick();
        iniciar = 1; tick();
        chk("restart", 16'(db_estado), 16'h1);
        tick();
        confirma = 1; tick();
        confirma = 0; tick();
        confirma = 1; tick();
        confirma = 0; tick();

        // 5: timeout beats a simultaneous move.
        timeout = 1; borda_movimento = 1;
        #1 chk("desloca_tmo", 16'(desloca), 16'h0);
        tick();
        timeout = 0; borda_movimento = 0;
        chk("perdeu_tmo", 16'({db_estado, perdeu, perdeu_timeout}), 16'({4'hE, 2'b11}));

        // 6: reach end of map, then reset aborts.
        iniciar = 0; tick();
        iniciar = 1; tick(); tick();
        confirma = 1; tick();
        confirma = 0; tick();
        confirma = 1; tick();
        confirma = 0; tick();
        borda_movimento = 1; tick();
        borda_movimento = 0; fim_mapa = 1; tick(); tick();
        chk("ganhou", 16'({db_estado, ganhou}), 16'({4'hA, 1'b1}));
        reset = 1; tick();
        reset = 0; fim_mapa = 0;
        chk("reset_mid_db", 16'(db_estado), 16'h0);
        chk("reset_mid_outs", 16'(dut_outs()), 16'h0);

        // Random play; rates chosen so games actually progress through every phase.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) iniciar = ~iniciar;
            if ($urandom_range(2) == 0) confirma = ~confirma;
            borda_movimento = ($urandom_range(2) == 0);
            colisao  = ($urandom_range(9) == 0);
            timeout  = ($urandom_range(19) == 0);
            fim_mapa = ($urandom_range(2) == 0);
            reset    = ($urandom_range(299) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
